// File: rtl/serial_pkg.sv
// Shared types and line levels for the serial pattern transmitter.
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

endpackage

// File: rtl/tx_bit_timer.sv
// Bit-period timer: counts clock cycles within a serial bit and emits a
// one-cycle bit_tick on the final cycle of each bit period.
module tx_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic bit_tick
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;

  assign bit_tick = (cnt_q == LAST_CNT);

  // Restart at the tick so the count never runs past the terminal value.
  always_ff @(posedge clock) begin
    if (reset || clear || bit_tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/serial_pattern_tx.sv
// Framed parallel-to-serial transmitter: start bit, data LSB first, optional
// even parity (enabled by defining PARITY_TX_EN), stop bit.
module serial_pattern_tx
  import serial_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              send,
  output logic              ready,
  output logic              serial_out,
  output logic              busy,
  output logic              done
);

  localparam int unsigned IDX_W = $clog2(DATA_W + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  tx_state_t         state_q;
  logic [DATA_W-1:0] shreg_q;
  logic [DATA_W-1:0] shreg_next;
  logic [IDX_W-1:0]  bit_idx_q;
  logic              serial_out_q;
  logic              ready_q;
  logic              busy_q;
  logic              bit_tick;
  logic              timer_clear;
`ifdef PARITY_TX_EN
  logic              parity_q;
`endif

  // Holding the timer in clear while idle makes every frame start from count 0.
  assign timer_clear = (state_q == IDLE);
  assign shreg_next  = shreg_q >> 1;

  tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (timer_clear),
    .bit_tick(bit_tick)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      bit_idx_q    <= '0;
      serial_out_q <= LINE_IDLE;
      ready_q      <= 1'b1;
      busy_q       <= 1'b0;
`ifdef PARITY_TX_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (send && ready_q) begin
            state_q      <= START;
            shreg_q      <= data_in;
            bit_idx_q    <= '0;
            serial_out_q <= LINE_START;
            ready_q      <= 1'b0;
            busy_q       <= 1'b1;
`ifdef PARITY_TX_EN
            parity_q     <= ^data_in;
`endif
          end
        end
        START: begin
          if (bit_tick) begin
            state_q      <= DATA;
            serial_out_q <= shreg_q[0];
          end
        end
        DATA: begin
          if (bit_tick) begin
            shreg_q <= shreg_next;
            if (bit_idx_q == LAST_IDX) begin
              bit_idx_q    <= '0;
`ifdef PARITY_TX_EN
              state_q      <= PARITY;
              serial_out_q <= parity_q;
`else
              state_q      <= STOP;
              serial_out_q <= LINE_IDLE;
`endif
            end else begin
              bit_idx_q    <= bit_idx_q + IDX_W'(1);
              serial_out_q <= shreg_next[0];
            end
          end
        end
`ifdef PARITY_TX_EN
        PARITY: begin
          if (bit_tick) begin
            state_q      <= STOP;
            serial_out_q <= LINE_IDLE;
          end
        end
`endif
        STOP: begin
          if (bit_tick) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q      <= IDLE;
          serial_out_q <= LINE_IDLE;
          ready_q      <= 1'b1;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign ready      = ready_q;
  assign busy       = busy_q;
  assign serial_out = serial_out_q;
  // Decoded from registered state and count only.
  assign done       = (state_q == STOP) && bit_tick;

endmodule
